key_param_ctrl: RTL and testbench

- Consumes the single-cycle press pulses from the debounced-key stage: one pulse per key for up, down and mode.
- Maintains the runtime Sobel edge threshold and the video display mode for the edge-detection pipeline.
- Threshold steps are accelerated when same-direction presses arrive in quick succession.
- Sits between the key debouncers and the image-processing and output-select logic.

---
 rtl/key_param_ctrl_if.sv | 18 +
 rtl/key_param_ctrl.sv | 55 +++++
 tb/tb_key_param_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/key_param_ctrl_if.sv
// key_param_ctrl_if: key press pulses in, threshold/display mode and update pulses out
interface key_param_ctrl_if;
    logic       key_up_flag;
    logic       key_dn_flag;
    logic       key_mode_flag;
    logic [7:0] threshold;
    logic [1:0] disp_mode;
    logic       th_upd;
    logic       mode_upd;
    modport master (
        output key_up_flag, key_dn_flag, key_mode_flag,
        input  threshold, disp_mode, th_upd, mode_upd
    );
    modport slave (
        input  key_up_flag, key_dn_flag, key_mode_flag,
        output threshold, disp_mode, th_upd, mode_upd
    );
endinterface

// File: rtl/key_param_ctrl.sv
// key_param_ctrl: runtime Sobel threshold with accelerated repeat stepping, plus display mode select
module key_param_ctrl #(
    parameter logic [7:0]  TH_INIT    = 8'd80,
    parameter logic [7:0]  TH_MIN     = 8'd8,
    parameter logic [7:0]  TH_MAX     = 8'd248,
    parameter logic [7:0]  STEP_SLOW  = 8'd1,
    parameter logic [7:0]  STEP_FAST  = 8'd8,
    parameter logic [25:0] REPEAT_WIN = 26'd25000000,
    parameter logic [1:0]  MODE_NUM   = 2'd3
) (
    input logic             sys_clk,
    input logic             sys_rst,
    key_param_ctrl_if.slave kp
);
    typedef enum logic [1:0] {IDLE, WIN_UP, WIN_DN} state_t;
    state_t      state, state_nx;
    logic [25:0] win_cnt, win_cnt_nx;
    logic        up, dn, fast;
    logic [7:0]  step, th_nx;
    logic [1:0]  mode_nx;
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            win_cnt      <= '0;
            kp.threshold <= TH_INIT;
            kp.disp_mode <= 2'd0;
            kp.th_upd    <= 1'b0;
            kp.mode_upd  <= 1'b0;
        end else begin
            state        <= state_nx;
            win_cnt      <= win_cnt_nx;
            kp.threshold <= th_nx;
            kp.disp_mode <= mode_nx;
            kp.th_upd    <= th_nx != kp.threshold;
            kp.mode_upd  <= mode_nx != kp.disp_mode;
        end
    end
    // Simultaneous up and down cancel out and are treated as no press.
    always_comb begin
        up         = kp.key_up_flag & ~kp.key_dn_flag;
        dn         = kp.key_dn_flag & ~kp.key_up_flag;
        fast       = (up && state == WIN_UP) || (dn && state == WIN_DN);
        step       = fast ? STEP_FAST : STEP_SLOW;
        state_nx   = up ? WIN_UP : dn ? WIN_DN :
                     (state != IDLE && win_cnt == REPEAT_WIN - 26'd1) ? IDLE : state;
        win_cnt_nx = (up || dn || state_nx == IDLE) ? 26'd0 : win_cnt + 26'd1;
        th_nx      = kp.threshold;
        if (up)
            th_nx = ({1'b0, kp.threshold} + {1'b0, step} > {1'b0, TH_MAX}) ? TH_MAX : kp.threshold + step;
        else if (dn)
            th_nx = ({1'b0, kp.threshold} < {1'b0, TH_MIN} + {1'b0, step}) ? TH_MIN : kp.threshold - step;
        mode_nx    = !kp.key_mode_flag ? kp.disp_mode :
                     (kp.disp_mode == MODE_NUM - 2'd1) ? 2'd0 : kp.disp_mode + 2'd1;
    end
endmodule

// File: tb/tb_key_param_ctrl.sv
// tb_key_param_ctrl: vector table plus hand sequences; expectations queued at drive, checked one cycle later
module tb_key_param_ctrl;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    key_param_ctrl_if kp ();
    key_param_ctrl #(.REPEAT_WIN(26'd100)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .kp(kp));
    always #5 sys_clk = ~sys_clk;
    typedef struct {
        logic       up, dn, mode;
        int         gap;
        logic [7:0] th;
        logic [1:0] md;
        logic       tu, mu;
    } vec_t;
    vec_t tbl[13];
    vec_t q[$];
    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic check_outputs(string tag, logic [7:0] th, logic [1:0] md, logic tu, logic mu);
        chk({tag, " threshold"}, int'(kp.threshold), int'(th));
        chk({tag, " disp_mode"}, int'(kp.disp_mode), int'(md));
        chk({tag, " th_upd"}, int'(kp.th_upd), int'(tu));
        chk({tag, " mode_upd"}, int'(kp.mode_upd), int'(mu));
    endtask
    // Idle gap cycles must show no update pulses; then one press cycle and its scoreboard check.
    task automatic press(vec_t v, string tag);
        vec_t e;
        for (int i = 0; i < v.gap; i++) begin
            @(negedge sys_clk);
            chk({tag, " idle th_upd"}, int'(kp.th_upd), 0);
            chk({tag, " idle mode_upd"}, int'(kp.mode_upd), 0);
        end
        q.push_back(v);
        kp.key_up_flag   = v.up;
        kp.key_dn_flag   = v.dn;
        kp.key_mode_flag = v.mode;
        @(posedge sys_clk);
        @(negedge sys_clk);
        kp.key_up_flag   = 1'b0;
        kp.key_dn_flag   = 1'b0;
        kp.key_mode_flag = 1'b0;
        e = q.pop_front();
        check_outputs(tag, e.th, e.md, e.tu, e.mu);
    endtask
    function automatic vec_t mk(logic u, logic d, logic m, int g, logic [7:0] th, logic [1:0] md, logic tu, logic mu);
        vec_t v;
        v.up = u; v.dn = d; v.mode = m; v.gap = g; v.th = th; v.md = md; v.tu = tu; v.mu = mu;
        return v;
    endfunction
    initial begin
        tbl[0]  = mk(1, 0, 0,   0,  81, 0, 1, 0);
        tbl[1]  = mk(1, 0, 0,  50,  89, 0, 1, 0);
        tbl[2]  = mk(1, 0, 0, 150,  90, 0, 1, 0);
        tbl[3]  = mk(1, 0, 0,  99,  98, 0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 100,  99, 0, 1, 0);
        tbl[5]  = mk(1, 1, 0,   5,  99, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0,  10,  98, 0, 1, 0);
        tbl[7]  = mk(0, 1, 0,  10,  90, 0, 1, 0);
        tbl[8]  = mk(1, 0, 0,  10,  91, 0, 1, 0);
        tbl[9]  = mk(0, 0, 1,   3,  91, 1, 0, 1);
        tbl[10] = mk(0, 0, 1,   0,  91, 2, 0, 1);
        tbl[11] = mk(0, 0, 1,   1,  91, 0, 0, 1);
        tbl[12] = mk(1, 0, 1,   2,  99, 1, 1, 1);
        kp.key_up_flag   = 1'b0;
        kp.key_dn_flag   = 1'b0;
        kp.key_mode_flag = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_outputs("reset", 8'd80, 2'd0, 1'b0, 1'b0);
        sys_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            check_outputs("post-reset idle", 8'd80, 2'd0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 13; i++)
            press(tbl[i], $sformatf("vec%0d", i));
        // Fast climb toward the top, then slow single steps to reach 245.
        for (int k = 1; k <= 18; k++)
            press(mk(1, 0, 0, 2, 8'(99 + 8 * k), 1, 1, 0), "fast up");
        press(mk(1, 0, 0, 120, 244, 1, 1, 0), "slow up 244");
        press(mk(1, 0, 0, 120, 245, 1, 1, 0), "slow up 245");
        press(mk(1, 0, 0, 10, 248, 1, 1, 0), "sat up");
        press(mk(1, 0, 0, 10, 248, 1, 0, 0), "at max");
        press(mk(0, 1, 0, 10, 247, 1, 1, 0), "turn down");
        for (int k = 1; k <= 29; k++)
            press(mk(0, 1, 0, 2, 8'(247 - 8 * k), 1, 1, 0), "fast dn");
        for (int k = 1; k <= 5; k++)
            press(mk(0, 1, 0, 120, 8'(15 - k), 1, 1, 0), "slow dn");
        press(mk(0, 1, 0, 10, 8, 1, 1, 0), "sat dn");
        press(mk(0, 1, 0, 10, 8, 1, 0, 0), "at min");
        press(mk(1, 0, 0, 5, 9, 1, 1, 0), "up from min");
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_outputs("mid reset", 8'd80, 2'd0, 1'b0, 1'b0);
        sys_rst = 1'b0;
        press(mk(1, 0, 0, 2, 81, 0, 1, 0), "up after reset");
        press(mk(1, 0, 0, 2, 89, 0, 1, 0), "fast after reset");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
